// File: rtl/esp_dma64_pkg.sv
// Shared widths, FSM state and size encodings for the 64-bit ESP DMA responder.
package esp_dma64_pkg;

  localparam int DMA_DATA_W = 64;
  localparam int DMA_IDX_W  = 32;
  localparam int DMA_LEN_W  = 32;
  localparam int DMA_SIZE_W = 3;

  // Burst engine state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_e;

  // Word size field carried on the ctrl channels (only recorded, never acted on)
  typedef enum logic [DMA_SIZE_W-1:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } dma_size_e;

endpackage

// File: rtl/esp_dma64_skid2.sv
// Two-entry valid/ready FIFO on the read data path. The producer never pushes
// into a full buffer unless a pop happens in the same cycle; the top module
// guarantees this through its credit check, so there is no in_ready.
module esp_dma64_skid2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] entry_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         push;
  logic         pop;

  assign pop  = (count_reg != 2'd0) && out_ready;
  assign push = in_valid && ((count_reg != 2'd2) || pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage; cleared on reset so out_data reads 0 while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
    end else if (push) begin
      entry_reg[wr_ptr_reg] <= in_data;
    end
  end

  assign out_valid = (count_reg != 2'd0);
  assign out_data  = entry_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/esp_dma64_mem_responder.sv
// Memory-side responder for the 64-bit ESP accelerator DMA interface.
// A single-port synchronous memory is shared between a burst engine (read and
// write bursts) and a host preload/readback port that only works in IDLE.
module esp_dma64_mem_responder
  import esp_dma64_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [DMA_IDX_W-1:0]  dma_read_ctrl_data_index,
  input  logic [DMA_LEN_W-1:0]  dma_read_ctrl_data_length,
  input  logic [DMA_SIZE_W-1:0] dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_valid,
  input  logic                  dma_read_chnl_ready,
  output logic [DMA_DATA_W-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [DMA_IDX_W-1:0]  dma_write_ctrl_data_index,
  input  logic [DMA_LEN_W-1:0]  dma_write_ctrl_data_length,
  input  logic [DMA_SIZE_W-1:0] dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_valid,
  output logic                  dma_write_chnl_ready,
  input  logic [DMA_DATA_W-1:0] dma_write_chnl_data,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [DMA_DATA_W-1:0] host_wdata,
  output logic [DMA_DATA_W-1:0] host_rdata,
  output logic                  host_ack,
  output logic                  busy,
  output logic [DMA_SIZE_W-1:0] last_size,
  output logic [31:0]           rd_beats,
  output logic [31:0]           wr_beats
);

  dma_state_e state_reg, state_next;

  logic [AW-1:0]         idx_reg;
  logic [DMA_LEN_W-1:0]  len_reg;
  logic [DMA_LEN_W-1:0]  beat_count_reg;   // beats delivered (RD) or accepted (WR)
  logic [DMA_LEN_W-1:0]  issue_cnt_reg;    // memory reads issued in the current read burst
  logic                  rd_pending_reg;   // a burst read is in flight in the memory
  logic [DMA_SIZE_W-1:0] last_size_reg;
  logic [31:0]           rd_beats_reg;
  logic [31:0]           wr_beats_reg;
  logic                  host_ack_reg;

  logic [DMA_DATA_W-1:0] mem_reg [MEM_WORDS];
  logic [DMA_DATA_W-1:0] mem_q_reg;
  logic [AW-1:0]         mem_addr;
  logic [DMA_DATA_W-1:0] mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic                  issue_rd;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rd_pop;
  logic                  wr_hs;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  space_ok;
  logic                  rd_more;
  logic [AW-1:0]         rd_addr;
  logic [AW-1:0]         wr_addr;
  logic                  unused_idx_hi;

  // Index bits above the memory depth are ignored: bursts wrap silently
  assign unused_idx_hi = ^{dma_read_ctrl_data_index[DMA_IDX_W-1:AW],
                           dma_write_ctrl_data_index[DMA_IDX_W-1:AW]};

  // Ctrl readies are gated by rst so every output reads 0 while in reset
  assign dma_read_ctrl_ready  = rst && (state_reg == IDLE) && !host_en;
  assign dma_write_ctrl_ready = rst && (state_reg == IDLE) && !host_en && !dma_read_ctrl_valid;
  assign dma_write_chnl_ready = (state_reg == WR);

  assign rd_accept = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign wr_accept = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign rd_pop    = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wr_hs     = dma_write_chnl_valid && dma_write_chnl_ready;

  // Credit check: buffered + in-flight beats, minus the one leaving now, must
  // leave a slot for a read issued this cycle (it lands two edges later)
  assign occupancy = {1'b0, buf_count} + {2'b00, rd_pending_reg} - {2'b00, rd_pop};
  assign space_ok  = (occupancy < 3'd2);
  assign rd_more   = (issue_cnt_reg < len_reg);
  assign rd_addr   = idx_reg + issue_cnt_reg[AW-1:0];
  assign wr_addr   = idx_reg + beat_count_reg[AW-1:0];

  // Next state and memory port arbitration; the first read of a burst is
  // issued in the acceptance cycle so data is visible two cycles later
  always_comb begin
    state_next = state_reg;
    mem_addr   = host_addr;
    mem_wdata  = host_wdata;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    issue_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (host_en) begin
          mem_we = host_we;
          mem_re = ~host_we;
        end else if (rd_accept) begin
          if (dma_read_ctrl_data_length != '0) begin
            state_next = RD;
            issue_rd   = 1'b1;
            mem_re     = 1'b1;
            mem_addr   = dma_read_ctrl_data_index[AW-1:0];
          end
        end else if (wr_accept) begin
          if (dma_write_ctrl_data_length != '0) state_next = WR;
        end
      end
      RD: begin
        mem_addr = rd_addr;
        if (rd_more && space_ok) begin
          issue_rd = 1'b1;
          mem_re   = 1'b1;
        end
        if (rd_pop && (beat_count_reg == len_reg - 32'd1)) state_next = IDLE;
      end
      WR: begin
        mem_addr  = wr_addr;
        mem_wdata = dma_write_chnl_data;
        if (wr_hs) begin
          mem_we = 1'b1;
          if (beat_count_reg == len_reg - 32'd1) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Request capture, beat counters and statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_reg        <= '0;
      len_reg        <= '0;
      beat_count_reg <= '0;
      issue_cnt_reg  <= '0;
      rd_pending_reg <= 1'b0;
      last_size_reg  <= '0;
      rd_beats_reg   <= '0;
      wr_beats_reg   <= '0;
      host_ack_reg   <= 1'b0;
    end else begin
      rd_pending_reg <= issue_rd;
      host_ack_reg   <= host_en && (state_reg == IDLE);
      if (rd_accept) begin
        idx_reg        <= dma_read_ctrl_data_index[AW-1:0];
        len_reg        <= dma_read_ctrl_data_length;
        last_size_reg  <= dma_read_ctrl_data_size;
        beat_count_reg <= '0;
        issue_cnt_reg  <= {31'd0, issue_rd};
      end else if (wr_accept) begin
        idx_reg        <= dma_write_ctrl_data_index[AW-1:0];
        len_reg        <= dma_write_ctrl_data_length;
        last_size_reg  <= dma_write_ctrl_data_size;
        beat_count_reg <= '0;
        issue_cnt_reg  <= '0;
      end else begin
        if (issue_rd) issue_cnt_reg <= issue_cnt_reg + 32'd1;
        if (rd_pop || wr_hs) beat_count_reg <= beat_count_reg + 32'd1;
      end
      if (rd_pop) rd_beats_reg <= rd_beats_reg + 32'd1;
      if (wr_hs)  wr_beats_reg <= wr_beats_reg + 32'd1;
    end
  end

  // Single-port memory with registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_reg[mem_addr] <= mem_wdata;
    if (mem_re) mem_q_reg <= mem_reg[mem_addr];
  end

  esp_dma64_skid2 #(.W(DMA_DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pending_reg),
    .in_data   (mem_q_reg),
    .out_valid (dma_read_chnl_valid),
    .out_ready (dma_read_chnl_ready),
    .out_data  (dma_read_chnl_data),
    .count     (buf_count)
  );

  assign host_rdata = rst ? mem_q_reg : '0;
  assign host_ack   = host_ack_reg;
  assign busy       = (state_reg != IDLE);
  assign last_size  = last_size_reg;
  assign rd_beats   = rd_beats_reg;
  assign wr_beats   = wr_beats_reg;

endmodule
